// File: rtl/img_pkg.sv
// Shared image-pipeline constants (also used by the ROM reader) and the FIFO operation encoding.
package img_pkg;

    localparam int DATA_W   = 24;
    localparam int IMG_COLS = 512;
    localparam int IMG_ROWS = 512;
    localparam int FIFO_AW  = 4;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        fifo_op_e op;
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: the head word is visible on rd_data whenever empty is low.
// The caller guarantees no push into a full FIFO unless it pops in the same cycle, and no pop when empty.
module sync_fifo_fwft
    import img_pkg::*;
#(
    parameter int DATA_W = img_pkg::DATA_W,
    parameter int AW     = img_pkg::FIFO_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW + 1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              empty_q;
    logic              full_q;
    fifo_op_e          op;

    assign op = fifo_op(wr_en, rd_en);

    // NOTE: storage is deliberately left out of reset; pointers and flags alone define valid contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (op)
                OP_PUSH: begin
                    count   <= count + 1'b1;
                    empty_q <= 1'b0;
                    full_q  <= (count == LVL_FULL - 1'b1);
                end
                OP_POP: begin
                    count   <= count - 1'b1;
                    full_q  <= 1'b0;
                    empty_q <= (count == LVL_ONE);
                end
                default: begin
                    // Idle or simultaneous push/pop: occupancy unchanged.
                end
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = count;

endmodule

// File: rtl/img_axis_packer.sv
// Buffers the free-running reader pixel stream and emits AXI4-Stream video with frame/line markers.
// Position counters follow the output handshakes, so tuser/tlast always describe the head pixel.
module img_axis_packer
    import img_pkg::*;
#(
    parameter int DATA_W   = img_pkg::DATA_W,
    parameter int IMG_COLS = img_pkg::IMG_COLS,
    parameter int IMG_ROWS = img_pkg::IMG_ROWS,
    parameter int FIFO_AW  = img_pkg::FIFO_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  img_din,
    input  logic               img_din_vld,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               frame_done,
    output logic               ovf,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int COL_W = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
    localparam int ROW_W = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROWS - 1);

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] head_data;
    logic              rd;
    logic              wr;
    logic              drop;
    logic              at_col_last;
    logic              at_row_last;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;

    assign m_axis_tvalid = !fifo_empty;
    assign rd            = m_axis_tvalid && m_axis_tready;
    // A full FIFO still accepts a pixel when the head leaves in the same cycle.
    assign wr            = img_din_vld && (!fifo_full || rd);
    assign drop          = img_din_vld && fifo_full && !rd;

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr),
        .wr_data (img_din),
        .rd_en   (rd),
        .rd_data (head_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign at_col_last = (col == COL_LAST);
    assign at_row_last = (row == ROW_LAST);

    // Sideband and data are forced low while idle so nothing stale leaks out after reset.
    assign m_axis_tdata = m_axis_tvalid ? head_data : '0;
    assign m_axis_tuser = m_axis_tvalid && (col == '0) && (row == '0);
    assign m_axis_tlast = m_axis_tvalid && at_col_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            frame_done <= rd && at_col_last && at_row_last;
            if (drop) begin
                ovf <= 1'b1;
            end
            if (rd) begin
                if (at_col_last) begin
                    col <= '0;
                    row <= at_row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_img_axis_packer.sv
// Directed bench for img_axis_packer with a 4x2 frame and a 16-deep FIFO.
module tb_img_axis_packer;

    localparam int DW    = 24;
    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int AW    = 4;
    localparam int FRAME = COLS * ROWS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] img_din = '0;
    logic          img_din_vld = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          frame_done;
    logic          ovf;
    logic [AW:0]   fifo_level;

    int errors = 0;
    int checks = 0;
    int pos    = 0;

    img_axis_packer #(
        .DATA_W   (DW),
        .IMG_COLS (COLS),
        .IMG_ROWS (ROWS),
        .FIFO_AW  (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .img_din       (img_din),
        .img_din_vld   (img_din_vld),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .ovf           (ovf),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_user(input int p);
        return (p % FRAME) == 0;
    endfunction

    function automatic logic exp_last(input int p);
        return (p % COLS) == (COLS - 1);
    endfunction

    task automatic apply_reset();
        rst_n         = 1'b0;
        img_din_vld   = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        rst_n = 1'b1;
        pos   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, ovf, fifo_level, m_axis_tdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got vld=%b user=%b last=%b fd=%b ovf=%b lvl=%0d data=%h exp all zero",
                     m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, ovf, fifo_level, m_axis_tdata);
        end
        rst_n = 1'b1;
        pos   = 0;
    endtask

    task automatic test_basic();
        int   got = 0;
        logic fd_exp = 1'b0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            img_din_vld = (k < 8);
            img_din     = DW'(k + 1);
            checks++;
            if (frame_done !== fd_exp) begin
                errors++;
                $display("FAIL basic_frame_done cycle=%0d got=%b exp=%b", k, frame_done, fd_exp);
            end
            fd_exp = 1'b0;
            if (m_axis_tvalid) begin
                checks++;
                if ({m_axis_tdata, m_axis_tuser, m_axis_tlast} !== {DW'(got + 1), exp_user(pos), exp_last(pos)}) begin
                    errors++;
                    $display("FAIL basic_pop%0d got data=%h user=%b last=%b exp data=%h user=%b last=%b", got,
                             m_axis_tdata, m_axis_tuser, m_axis_tlast, DW'(got + 1), exp_user(pos), exp_last(pos));
                end
                fd_exp = ((pos % FRAME) == FRAME - 1);
                pos    = (pos + 1) % FRAME;
                got++;
            end
            tick();
        end
        img_din_vld = 1'b0;
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=8", got);
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_single();
        m_axis_tready = 1'b0;
        img_din_vld   = 1'b1;
        img_din       = 24'hABCDEF;
        checks++;
        if ({m_axis_tvalid, fifo_level} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL single_pre got vld=%b lvl=%0d exp vld=0 lvl=0", m_axis_tvalid, fifo_level);
        end
        tick();
        img_din_vld = 1'b0;
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, fifo_level} !== {1'b1, 24'hABCDEF, exp_user(pos), 5'd1}) begin
            errors++;
            $display("FAIL single_latency got vld=%b data=%h user=%b lvl=%0d exp vld=1 data=abcdef user=%b lvl=1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tuser, fifo_level, exp_user(pos));
        end
        m_axis_tready = 1'b1;
        tick();
        pos = (pos + 1) % FRAME;
        checks++;
        if ({m_axis_tvalid, fifo_level} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL single_drain got vld=%b lvl=%0d exp vld=0 lvl=0", m_axis_tvalid, fifo_level);
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_overflow();
        int got = 0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            img_din_vld = 1'b1;
            img_din     = DW'(32'h100 + i);
            tick();
        end
        img_din_vld = 1'b0;
        checks++;
        if ({fifo_level, ovf} !== {5'd16, 1'b0}) begin
            errors++;
            $display("FAIL ovf_fill got lvl=%0d ovf=%b exp lvl=16 ovf=0", fifo_level, ovf);
        end
        img_din_vld = 1'b1;
        img_din     = 24'h0001FF;
        tick();
        img_din_vld = 1'b0;
        checks++;
        if ({fifo_level, ovf} !== {5'd16, 1'b1}) begin
            errors++;
            $display("FAIL ovf_drop got lvl=%0d ovf=%b exp lvl=16 ovf=1", fifo_level, ovf);
        end
        tick();
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got=%b exp=1", ovf);
        end
        m_axis_tready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (m_axis_tvalid) begin
                checks++;
                if ({m_axis_tdata, m_axis_tuser, m_axis_tlast} !== {DW'(32'h100 + got), exp_user(pos), exp_last(pos)}) begin
                    errors++;
                    $display("FAIL ovf_pop%0d got data=%h user=%b last=%b exp data=%h user=%b last=%b", got,
                             m_axis_tdata, m_axis_tuser, m_axis_tlast, DW'(32'h100 + got), exp_user(pos), exp_last(pos));
                end
                pos = (pos + 1) % FRAME;
                got++;
            end
            tick();
        end
        checks++;
        if (got != 16 || ovf !== 1'b1 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL ovf_drain got count=%0d ovf=%b lvl=%0d exp count=16 ovf=1 lvl=0", got, ovf, fifo_level);
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        int got = 0;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            img_din_vld = 1'b1;
            img_din     = DW'(32'h200 + i);
            tick();
        end
        img_din_vld = 1'b0;
        checks++;
        if (fifo_level !== 5'd16) begin
            errors++;
            $display("FAIL full_fill got lvl=%0d exp=16", fifo_level);
        end
        for (int k = 0; k < 10; k++) begin
            img_din_vld   = 1'b1;
            img_din       = DW'(32'h210 + k);
            m_axis_tready = 1'b1;
            checks++;
            if ({m_axis_tvalid, fifo_level, m_axis_tdata, m_axis_tuser, m_axis_tlast} !==
                {1'b1, 5'd16, DW'(32'h200 + got), exp_user(pos), exp_last(pos)}) begin
                errors++;
                $display("FAIL full_pushpop%0d got vld=%b lvl=%0d data=%h user=%b last=%b exp vld=1 lvl=16 data=%h user=%b last=%b",
                         k, m_axis_tvalid, fifo_level, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                         DW'(32'h200 + got), exp_user(pos), exp_last(pos));
            end
            pos = (pos + 1) % FRAME;
            got++;
            tick();
        end
        img_din_vld = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (m_axis_tvalid) begin
                checks++;
                if ({m_axis_tdata, m_axis_tuser, m_axis_tlast} !== {DW'(32'h200 + got), exp_user(pos), exp_last(pos)}) begin
                    errors++;
                    $display("FAIL full_drain%0d got data=%h user=%b last=%b exp data=%h user=%b last=%b", got,
                             m_axis_tdata, m_axis_tuser, m_axis_tlast, DW'(32'h200 + got), exp_user(pos), exp_last(pos));
                end
                pos = (pos + 1) % FRAME;
                got++;
            end
            tick();
        end
        checks++;
        if (got != 26 || ovf !== 1'b0 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL full_end got count=%0d ovf=%b lvl=%0d exp count=26 ovf=0 lvl=0", got, ovf, fifo_level);
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_random_stall();
        int            fed = 0;
        int            got = 0;
        int            users = 0;
        int            fd_seen = 0;
        logic          fd_exp = 1'b0;
        logic          stall = 1'b0;
        logic [DW+1:0] prev = '0;
        apply_reset();
        for (int cyc = 0; cyc < 400 && got < 3 * FRAME; cyc++) begin
            img_din_vld = ((cyc % 2) == 0) && (fed < 3 * FRAME);
            img_din     = DW'(32'h300 + fed);
            if (img_din_vld) fed++;
            m_axis_tready = ($urandom_range(0, 3) != 0);
            checks++;
            if (frame_done !== fd_exp) begin
                errors++;
                $display("FAIL rand_frame_done cycle=%0d got=%b exp=%b", cyc, frame_done, fd_exp);
            end
            if (frame_done) fd_seen++;
            if (stall) begin
                checks++;
                if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast} !== {1'b1, prev}) begin
                    errors++;
                    $display("FAIL rand_stall cycle=%0d got vld=%b data=%h user=%b last=%b exp held vld=1 {data,user,last}=%h",
                             cyc, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, prev);
                end
            end
            fd_exp = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if ({m_axis_tdata, m_axis_tuser, m_axis_tlast} !== {DW'(32'h300 + got), exp_user(pos), exp_last(pos)}) begin
                    errors++;
                    $display("FAIL rand_pop%0d got data=%h user=%b last=%b exp data=%h user=%b last=%b", got,
                             m_axis_tdata, m_axis_tuser, m_axis_tlast, DW'(32'h300 + got), exp_user(pos), exp_last(pos));
                end
                if (m_axis_tuser) users++;
                fd_exp = ((pos % FRAME) == FRAME - 1);
                pos    = (pos + 1) % FRAME;
                got++;
            end
            stall = m_axis_tvalid && !m_axis_tready;
            prev  = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
            tick();
        end
        img_din_vld   = 1'b0;
        m_axis_tready = 1'b0;
        if (frame_done) fd_seen++;
        checks++;
        if (got != 3 * FRAME || users != 3 || fd_seen != 3 || frame_done !== fd_exp || ovf !== 1'b0 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL rand_end got count=%0d tuser=%0d fd=%0d last_fd=%b ovf=%b lvl=%0d exp count=24 tuser=3 fd=3 last_fd=1 ovf=0 lvl=0",
                     got, users, fd_seen, frame_done, ovf, fifo_level);
        end
    endtask

    task automatic test_mid_reset();
        int got = 0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 20 && got < 5; k++) begin
            img_din_vld = (k < 8);
            img_din     = DW'(32'h500 + k);
            if (m_axis_tvalid) begin
                checks++;
                if (m_axis_tdata !== DW'(32'h500 + got)) begin
                    errors++;
                    $display("FAIL midrst_pop%0d got data=%h exp data=%h", got, m_axis_tdata, DW'(32'h500 + got));
                end
                got++;
            end
            tick();
        end
        rst_n       = 1'b0;
        img_din_vld = 1'b0;
        tick();
        rst_n = 1'b1;
        pos   = 0;
        checks++;
        if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, ovf, fifo_level, m_axis_tdata} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got vld=%b user=%b last=%b fd=%b ovf=%b lvl=%0d data=%h exp all zero",
                     m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, ovf, fifo_level, m_axis_tdata);
        end
        m_axis_tready = 1'b0;
        img_din_vld   = 1'b1;
        img_din       = 24'h0005AA;
        tick();
        img_din_vld = 1'b0;
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, fifo_level} !== {1'b1, 24'h0005AA, 1'b1, 5'd1}) begin
            errors++;
            $display("FAIL midrst_restart got vld=%b data=%h user=%b lvl=%0d exp vld=1 data=0005aa user=1 lvl=1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tuser, fifo_level);
        end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_random_stall();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
